// File: rtl/loader_pkg.sv
// loader_pkg: loader FSM states and byte-stream framing constants shared by program_loader and word_assembler.
package loader_pkg;
  localparam int BCNT_W = 2;
  localparam int LEN_BYTES = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs big-endian host bytes into 32-bit words.
//   clk, reset (async, active-low) | clear: sync clear on load start
//   shift_en: accept in_byte as the next data byte
//   word: current shift contents with in_byte appended
//   word_done: 4th byte of a word is being accepted this cycle
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_done
);
  logic [23:0]       shift;
  logic [BCNT_W-1:0] byte_cnt;
  assign word = {shift, in_byte};
  assign word_done = shift_en && &byte_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shift <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shift <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      shift <= word[23:0];
      byte_cnt <= byte_cnt + 1'b1;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed, checksummed byte stream into instruction memory, then releases the core.
//   clk, reset (async, active-low), start: begin load from IDLE/DONE/ERROR
//   in_valid/in_byte/in_ready: host byte handshake
//   init_mode/write_enable/init_address/init_instruction: instruction memory init port
//   core_run, done, error, words_written: load status
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [31:0]       init_instruction,
  output logic              core_run,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);
  state_t state, next;
  logic [8*LEN_BYTES-1:0] len, n;
  logic [7:0]  checksum;
  logic [31:0] word;
  logic        xfer, load, data_xfer, word_done, last_word, len_bad;
  assign in_ready = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
  assign xfer = in_valid && in_ready;
  assign load = start && state inside {S_IDLE, S_DONE, S_ERROR};
  assign data_xfer = xfer && state == S_DATA;
  assign n = {in_byte, len[7:0]};
  assign len_bad = n == '0 || int'(n) > DEPTH;
  // words_written doubles as the write index: both count words written this load
  assign last_word = int'(words_written) + 1 == int'(len);
  word_assembler u_asm (
    .clk(clk), .reset(reset), .clear(load), .shift_en(data_xfer),
    .in_byte(in_byte), .word(word), .word_done(word_done)
  );
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: next = start ? S_LEN_LO : state;
      S_LEN_LO: next = xfer ? S_LEN_HI : state;
      S_LEN_HI: next = !xfer ? state : len_bad ? S_ERROR : S_DATA;
      S_DATA:   next = word_done && last_word ? S_CHECK : state;
      S_CHECK:  next = !xfer ? state : in_byte == checksum ? S_DONE : S_ERROR;
      default:  next = S_IDLE;
    endcase
  end
  // status outputs are registered from the next state so they change with it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      len <= '0;
      checksum <= '0;
      words_written <= '0;
      init_address <= '0;
      init_instruction <= '0;
      write_enable <= 1'b0;
      init_mode <= 1'b0;
      core_run <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= next;
      init_mode <= next inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_ERROR};
      done <= next == S_DONE;
      core_run <= next == S_DONE;
      error <= next == S_ERROR;
      write_enable <= word_done;
      if (load) begin
        checksum <= '0;
        words_written <= '0;
      end
      if (xfer && state == S_LEN_LO) len[7:0] <= in_byte;
      if (xfer && state == S_LEN_HI) len[15:8] <= in_byte;
      if (data_xfer) checksum <= checksum ^ in_byte;
      if (word_done) begin
        init_address <= words_written[ADDR_W-1:0];
        init_instruction <= word;
        words_written <= words_written + 1'b1;
      end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the single-cycle MIPS core's instruction-fetch init interface.
- Accepts a host byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory through init_mode/write_enable/init_address/init_instruction.
- Verifies a checksum, then releases the core to run.

Parameters:
- ADDR_W, 12, width of init_address (word index into instruction memory).
- DEPTH, 1024, maximum number of words a program may contain; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  host byte valid.
- in_byte  input  8  host byte.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready.
- init_mode  output  1  drives the core's init_mode.
- write_enable  output  1  one-cycle instruction-memory write strobe.
- init_address  output  ADDR_W  word index for the current write.
- init_instruction  output  32  word to write.
- core_run  output  1  high when the core may execute; the core top gates its reset with this.
- done  output  1  load completed with a good checksum.
- error  output  1  load failed (bad length or bad checksum).
- words_written  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset (asynchronous, reset low):
  - State is IDLE.
  - All outputs are 0, except in_ready, which is 0 because of the state.
  - Internal counters, shift register and checksum are 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- in_ready is 1 only in LEN_LO, LEN_HI, DATA and CHECK; it is combinational from state only.
- init_mode:
  - 1 in LEN_LO, LEN_HI, DATA, CHECK and ERROR.
  - 0 in IDLE and DONE.
  - Registered with the state.
- IDLE → LEN_LO on start. On entry:
  - clear checksum, byte_cnt, word_idx, words_written, done, error;
  - set core_run = 0.
- LEN_LO: on transfer, N[7:0] = in_byte, then go to LEN_HI.
- LEN_HI: on transfer, N[15:8] = in_byte.
  - If the 16-bit N == 0 or N > DEPTH, go to ERROR.
  - Otherwise go to DATA.
  - Length bytes are excluded from the checksum.
- DATA, on each transfer:
  - shift = {shift[23:0], in_byte};
  - checksum ^= in_byte;
  - byte_cnt increments modulo 4.
- DATA, on the transfer where byte_cnt == 3, the following values register on that same edge:
  - init_instruction = {shift[23:0], in_byte};
  - init_address = word_idx;
  - write_enable = 1;
  - word_idx and words_written increment.
- write_enable:
  - Is high for exactly one cycle, then returns to 0.
  - init_address and init_instruction hold until the next write.
  - Write latency is 1 cycle after the 4th byte is accepted.
  - in_ready is not dropped; the next byte may transfer in the write cycle.
- When the word just written is word N−1, go to CHECK.
- CHECK: on transfer, if in_byte == checksum go to DONE, else go to ERROR.
- DONE: done = 1, core_run = 1, init_mode = 0.
- ERROR: error = 1, core_run = 0, init_mode = 1.
- DONE or ERROR → LEN_LO on start, with the same entry clears as from IDLE. core_run falls on the cycle after start.
- start is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- Bytes presented while in_ready = 0 are not consumed; the host must hold them.
- in_valid gaps stall the machine in place with no timeout.
- Reset mid-load:
  - Returns to IDLE immediately.
  - Partially written memory is left as is.
  - core_run stays 0 until a full good load completes.
- The final word at address DEPTH−1 is legal; word_idx never wraps within a load.

Decomposition:
- Package loader_pkg holds:
  - the state enum (7 states);
  - the byte-count width constant (2);
  - the LEN_BYTES = 2 constant.
- One natural sub-module, word_assembler:
  - contains the shift register, byte_cnt and word_done strobe;
  - is reset by the same asynchronous, active-low reset;
  - is cleared synchronously on load start.

Test Plan:
- Good 2-word load: start; bytes 02 00, 20 08 00 05, 00 00 00 0C, checksum 0x21.
  - Required: write_enable pulses with (addr 0, 0x20080005) and (addr 1, 0x0000000C).
  - Required: done = 1, core_run = 1, init_mode = 0, words_written = 2.
- Length errors:
  - Bytes 00 00 → error = 1 after the 2nd byte, no write_enable, core_run = 0.
  - Length 0x0401 (1025 > DEPTH) → error = 1.
- Bad checksum: 1-word load of 0xDEADBEEF with checksum 0x00 (correct value 0x22).
  - Required: one write at addr 0, then error = 1, init_mode stays 1, core_run = 0.
- Backpressure/gaps: the good 2-word load with in_valid low for 3 cycles between every byte.
  - Required: identical writes and done.
  - Required: no extra or duplicated writes; write_enable never high for more than 1 cycle.
- Reset mid-load: assert reset after 5 data bytes.
  - Required: all outputs 0 asynchronously, state IDLE.
  - Required: a subsequent good load completes correctly from addr 0.
- Restart from DONE: start while done = 1.
  - Required: core_run = 0 and done = 0 next cycle, init_mode = 1.
  - Required: a new 1-word load overwrites addr 0.
